// File: rtl/l2_wb_pkg.sv
// Shared constants and types for the L2 writeback-request engine.
package l2_wb_pkg;

    localparam logic [7:0] MSG_WB_REQ = 8'h0C;
    localparam logic [7:0] MSG_WB_ACK = 8'h0D;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        WRITE  = 2'd2,
        ACK    = 2'd3
    } fsm_t;

    localparam logic [1:0] VD_INV   = 2'b00;
    localparam logic [1:0] VD_CLEAN = 2'b10;
    localparam logic [1:0] VD_DIRTY = 2'b11;

    localparam logic [1:0] MESI_I = 2'b00;
    localparam logic [1:0] MESI_S = 2'b01;
    localparam logic [1:0] MESI_E = 2'b10;
    localparam logic [1:0] MESI_M = 2'b11;

    function automatic int way_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/l2_wb_tag_cmp.sv
// Per-way tag comparators with a lowest-way-wins priority encoder.
module l2_wb_tag_cmp
    import l2_wb_pkg::*;
#(
    parameter int NUM_WAYS = 2,
    parameter int TAG_W    = 26,
    parameter int WAY_W    = way_bits(NUM_WAYS)
) (
    input  logic [NUM_WAYS*TAG_W-1:0] way_tags,
    input  logic [NUM_WAYS-1:0]       way_valid,
    input  logic [TAG_W-1:0]          tag,
    output logic                      hit,
    output logic [WAY_W-1:0]          way
);

    always_comb begin
        hit = 1'b0;
        way = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (!hit && way_valid[w] && (way_tags[w*TAG_W +: TAG_W] == tag)) begin
                hit = 1'b1;
                way = WAY_W'(w);
            end
        end
    end

endmodule

// File: rtl/l2_wb_req_unit.sv
// Set-associative L2 writeback-request engine: accepts WB_REQ on msg3,
// updates data/directory on a hit and returns WB_ACK on msg2.
module l2_wb_req_unit
    import l2_wb_pkg::*;
#(
    parameter int          SET_BITS = 4,
    parameter int          NUM_WAYS = 2,
    parameter int          TAG_W    = 26,
    parameter int          DATA_W   = 64,
    parameter int          SRC_W    = 6,
    parameter logic [7:0]  WB_TYPE  = MSG_WB_REQ,
    parameter logic [7:0]  ACK_TYPE = MSG_WB_ACK,
    localparam int         NUM_SETS = 2**SET_BITS,
    localparam int         WAY_W    = way_bits(NUM_WAYS),
    localparam int         SHARE_W  = 2**SRC_W,
    localparam int         ADDR_W   = TAG_W + SET_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                msg3_valid,
    output logic                msg3_ready,
    input  logic [7:0]          msg3_type,
    input  logic [SRC_W-1:0]    msg3_source,
    input  logic [ADDR_W-1:0]   msg3_addr,
    input  logic [DATA_W-1:0]   msg3_data,
    output logic                msg2_valid,
    input  logic                msg2_ready,
    output logic [7:0]          msg2_type,
    output logic [SRC_W-1:0]    msg2_dest,
    output logic                msg2_hit,
    input  logic                fill_valid,
    output logic                fill_ready,
    input  logic [SET_BITS-1:0] fill_set,
    input  logic [WAY_W-1:0]    fill_way,
    input  logic [TAG_W-1:0]    fill_tag,
    input  logic [DATA_W-1:0]   fill_data,
    input  logic [SRC_W-1:0]    fill_owner,
    input  logic [SHARE_W-1:0]  fill_share,
    input  logic [SET_BITS-1:0] dbg_set,
    input  logic [WAY_W-1:0]    dbg_way,
    output logic [TAG_W-1:0]    dbg_tag,
    output logic [1:0]          dbg_vd,
    output logic [1:0]          dbg_state,
    output logic [DATA_W-1:0]   dbg_data,
    output logic [SRC_W-1:0]    dbg_owner,
    output logic [SHARE_W-1:0]  dbg_share,
    output logic [7:0]          wb_age,
    output logic [15:0]         hit_cnt,
    output logic [15:0]         miss_cnt
);

    fsm_t fsm;

    logic [SRC_W-1:0]    cap_source;
    logic [TAG_W-1:0]    cap_tag;
    logic [SET_BITS-1:0] cap_set;
    logic [DATA_W-1:0]   cap_data;
    logic                hit_q;
    logic [WAY_W-1:0]    way_q;

    logic [TAG_W-1:0]   tag_mem   [NUM_SETS][NUM_WAYS];
    logic [1:0]         vd_mem    [NUM_SETS][NUM_WAYS];
    logic [1:0]         state_mem [NUM_SETS][NUM_WAYS];
    logic [DATA_W-1:0]  data_mem  [NUM_SETS][NUM_WAYS];
    logic [SRC_W-1:0]   owner_mem [NUM_SETS][NUM_WAYS];
    logic [SHARE_W-1:0] share_mem [NUM_SETS][NUM_WAYS];

    logic [NUM_WAYS*TAG_W-1:0] set_tags;
    logic [NUM_WAYS-1:0]       set_valid;
    logic                      lu_hit;
    logic [WAY_W-1:0]          lu_way;
    logic                      accept;
    logic                      fill_en;
    logic                      wr_hit;

    assign msg3_ready = (fsm == IDLE) && (msg3_type == WB_TYPE);
    assign fill_ready = (fsm != WRITE);
    assign accept     = msg3_valid && msg3_ready;
    assign fill_en    = fill_valid && fill_ready;
    assign wr_hit     = (fsm == WRITE) && hit_q;

    always_comb begin
        set_tags  = '0;
        set_valid = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            set_tags[w*TAG_W +: TAG_W] = tag_mem[cap_set][w];
            set_valid[w]               = vd_mem[cap_set][w][1];
        end
    end

    l2_wb_tag_cmp #(
        .NUM_WAYS (NUM_WAYS),
        .TAG_W    (TAG_W),
        .WAY_W    (WAY_W)
    ) u_tag_cmp (
        .way_tags  (set_tags),
        .way_valid (set_valid),
        .tag       (cap_tag),
        .hit       (lu_hit),
        .way       (lu_way)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm        <= IDLE;
            cap_source <= '0;
            cap_tag    <= '0;
            cap_set    <= '0;
            cap_data   <= '0;
            hit_q      <= 1'b0;
            way_q      <= '0;
            msg2_valid <= 1'b0;
            msg2_type  <= '0;
            msg2_dest  <= '0;
            msg2_hit   <= 1'b0;
            wb_age     <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            // Age stays 0 until the first accept, then saturates at 255.
            if (accept)
                wb_age <= 8'd1;
            else if (wb_age != 8'd0 && wb_age != 8'hFF)
                wb_age <= wb_age + 8'd1;

            case (fsm)
                IDLE: begin
                    if (accept) begin
                        cap_source <= msg3_source;
                        cap_tag    <= msg3_addr[ADDR_W-1:SET_BITS];
                        cap_set    <= msg3_addr[SET_BITS-1:0];
                        cap_data   <= msg3_data;
                        fsm        <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    hit_q <= lu_hit;
                    way_q <= lu_way;
                    fsm   <= WRITE;
                end
                WRITE: begin
                    if (hit_q)
                        hit_cnt <= hit_cnt + 16'd1;
                    else
                        miss_cnt <= miss_cnt + 16'd1;
                    msg2_valid <= 1'b1;
                    msg2_type  <= ACK_TYPE;
                    msg2_dest  <= cap_source;
                    msg2_hit   <= hit_q;
                    fsm        <= ACK;
                end
                ACK: begin
                    if (msg2_ready) begin
                        msg2_valid <= 1'b0;
                        msg2_type  <= '0;
                        msg2_dest  <= '0;
                        msg2_hit   <= 1'b0;
                        fsm        <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    // Fill and hit-write never coincide: fill_ready is low in WRITE.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < NUM_SETS; s++)
                for (int unsigned w = 0; w < NUM_WAYS; w++)
                    vd_mem[s][w] <= VD_INV;
        end else begin
            if (wr_hit)
                vd_mem[cap_set][way_q] <= VD_DIRTY;
            if (fill_en)
                vd_mem[fill_set][fill_way] <= VD_CLEAN;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_hit) begin
            data_mem[cap_set][way_q]              <= cap_data;
            state_mem[cap_set][way_q]             <= MESI_I;
            share_mem[cap_set][way_q][cap_source] <= 1'b0;
            if (owner_mem[cap_set][way_q] == cap_source)
                owner_mem[cap_set][way_q] <= '0;
        end
        if (fill_en) begin
            tag_mem[fill_set][fill_way]   <= fill_tag;
            data_mem[fill_set][fill_way]  <= fill_data;
            state_mem[fill_set][fill_way] <= MESI_I;
            owner_mem[fill_set][fill_way] <= fill_owner;
            share_mem[fill_set][fill_way] <= fill_share;
        end
    end

    assign dbg_tag   = tag_mem[dbg_set][dbg_way];
    assign dbg_vd    = vd_mem[dbg_set][dbg_way];
    assign dbg_state = state_mem[dbg_set][dbg_way];
    assign dbg_data  = data_mem[dbg_set][dbg_way];
    assign dbg_owner = owner_mem[dbg_set][dbg_way];
    assign dbg_share = share_mem[dbg_set][dbg_way];

endmodule

// File: tb/tb_l2_wb_req_unit.sv
// Self-checking bench for l2_wb_req_unit against a line-level reference model.
`timescale 1ns/1ps
module tb_l2_wb_req_unit;

    localparam int SETS = 16;
    localparam int WAYS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        msg3_valid = 1'b0;
    logic        msg3_ready;
    logic [7:0]  msg3_type = 8'h0C;
    logic [5:0]  msg3_source = '0;
    logic [29:0] msg3_addr = '0;
    logic [63:0] msg3_data = '0;
    logic        msg2_valid;
    logic        msg2_ready = 1'b0;
    logic [7:0]  msg2_type;
    logic [5:0]  msg2_dest;
    logic        msg2_hit;
    logic        fill_valid = 1'b0;
    logic        fill_ready;
    logic [3:0]  fill_set = '0;
    logic [0:0]  fill_way = '0;
    logic [25:0] fill_tag = '0;
    logic [63:0] fill_data = '0;
    logic [5:0]  fill_owner = '0;
    logic [63:0] fill_share = '0;
    logic [3:0]  dbg_set = '0;
    logic [0:0]  dbg_way = '0;
    logic [25:0] dbg_tag;
    logic [1:0]  dbg_vd;
    logic [1:0]  dbg_state;
    logic [63:0] dbg_data;
    logic [5:0]  dbg_owner;
    logic [63:0] dbg_share;
    logic [7:0]  wb_age;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    l2_wb_req_unit #(
        .SET_BITS (4),
        .NUM_WAYS (2),
        .TAG_W    (26),
        .DATA_W   (64),
        .SRC_W    (6),
        .WB_TYPE  (8'h0C),
        .ACK_TYPE (8'h0D)
    ) dut (
        .clk (clk), .rst (rst),
        .msg3_valid (msg3_valid), .msg3_ready (msg3_ready), .msg3_type (msg3_type),
        .msg3_source (msg3_source), .msg3_addr (msg3_addr), .msg3_data (msg3_data),
        .msg2_valid (msg2_valid), .msg2_ready (msg2_ready), .msg2_type (msg2_type),
        .msg2_dest (msg2_dest), .msg2_hit (msg2_hit),
        .fill_valid (fill_valid), .fill_ready (fill_ready), .fill_set (fill_set),
        .fill_way (fill_way), .fill_tag (fill_tag), .fill_data (fill_data),
        .fill_owner (fill_owner), .fill_share (fill_share),
        .dbg_set (dbg_set), .dbg_way (dbg_way), .dbg_tag (dbg_tag), .dbg_vd (dbg_vd),
        .dbg_state (dbg_state), .dbg_data (dbg_data), .dbg_owner (dbg_owner),
        .dbg_share (dbg_share),
        .wb_age (wb_age), .hit_cnt (hit_cnt), .miss_cnt (miss_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one record per cache line plus counters.
    logic [1:0]  m_vd    [SETS][WAYS];
    logic [25:0] m_tag   [SETS][WAYS];
    logic [63:0] m_data  [SETS][WAYS];
    logic [5:0]  m_owner [SETS][WAYS];
    logic [63:0] m_share [SETS][WAYS];
    int          m_hits;
    int          m_misses;

    typedef struct {
        int         waitc;
        int         lat;
        int         unstable;
        int         leaked;
        logic       hit;
        logic [7:0] typ;
        logic [5:0] dest;
        logic [7:0] age1;
        logic [7:0] age_ack;
        logic       ready_after;
    } wb_obs_t;

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                m_vd[s][w] = 2'b00;
        m_hits   = 0;
        m_misses = 0;
    endfunction

    function automatic void model_fill(input int s, input int w, input logic [25:0] t,
                                       input logic [63:0] d, input logic [5:0] o,
                                       input logic [63:0] sh);
        m_vd[s][w]    = 2'b10;
        m_tag[s][w]   = t;
        m_data[s][w]  = d;
        m_owner[s][w] = o;
        m_share[s][w] = sh;
    endfunction

    function automatic logic model_wb(input logic [5:0] src, input logic [29:0] addr,
                                      input logic [63:0] d);
        int s;
        s = int'(addr[3:0]);
        for (int w = 0; w < WAYS; w++) begin
            if (m_vd[s][w][1] && m_tag[s][w] == addr[29:4]) begin
                m_data[s][w] = d;
                m_vd[s][w]   = 2'b11;
                if (m_owner[s][w] == src)
                    m_owner[s][w] = '0;
                m_share[s][w][src] = 1'b0;
                m_hits++;
                return 1'b1;
            end
        end
        m_misses++;
        return 1'b0;
    endfunction

    // Drivers start and end just after a falling edge.
    task automatic do_fill(input int s, input int w, input logic [25:0] t,
                           input logic [63:0] d, input logic [5:0] o, input logic [63:0] sh);
        fill_set = 4'(s); fill_way = 1'(w); fill_tag = t; fill_data = d;
        fill_owner = o; fill_share = sh; fill_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        fill_valid = 1'b0;
        model_fill(s, w, t, d, o, sh);
    endtask

    task automatic do_wb(input logic [5:0] src, input logic [29:0] addr,
                         input logic [63:0] d, input int hold, output wb_obs_t o);
        msg3_valid = 1'b1; msg3_type = 8'h0C; msg3_source = src;
        msg3_addr = addr; msg3_data = d;
        o.waitc = 0;
        while (msg3_ready !== 1'b1 && o.waitc < 20) begin
            @(negedge clk);
            o.waitc++;
        end
        @(posedge clk);
        @(negedge clk);
        msg3_valid = 1'b0;
        o.age1 = wb_age;
        o.lat  = 1;
        while (msg2_valid !== 1'b1 && o.lat < 20) begin
            @(negedge clk);
            o.lat++;
        end
        o.typ = msg2_type; o.dest = msg2_dest; o.hit = msg2_hit; o.age_ack = wb_age;
        o.unstable = 0; o.leaked = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (msg2_valid !== 1'b1 || msg2_type !== o.typ || msg2_dest !== o.dest ||
                msg2_hit !== o.hit)
                o.unstable++;
            if (msg3_ready !== 1'b0)
                o.leaked++;
        end
        msg2_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        msg2_ready = 1'b0;
        o.ready_after = msg3_ready && !msg2_valid;
    endtask

    task automatic scan_lines(output int bad);
        bad = 0;
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                dbg_set = 4'(s);
                dbg_way = 1'(w);
                #1;
                if (dbg_vd !== m_vd[s][w])
                    bad++;
                if (m_vd[s][w] != 2'b00 &&
                    (dbg_tag !== m_tag[s][w] || dbg_data !== m_data[s][w] ||
                     dbg_owner !== m_owner[s][w] || dbg_share !== m_share[s][w]))
                    bad++;
                if (m_vd[s][w] == 2'b11 && dbg_state !== 2'b00)
                    bad++;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        n_checks++;
        if ({msg2_valid, msg2_type, msg2_dest, msg2_hit} !== '0) begin
            n_fail++;
            $display("FAIL reset_msg2: got v=%b t=%h d=%h h=%b want all zero",
                     msg2_valid, msg2_type, msg2_dest, msg2_hit);
        end
        n_checks++;
        if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got hit=%0d miss=%0d want 0/0", hit_cnt, miss_cnt);
        end
        n_checks++;
        if (msg3_ready !== 1'b1 || fill_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got msg3_ready=%b fill_ready=%b want 1/1",
                     msg3_ready, fill_ready);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (wb_age !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_age: got %0d want 0", wb_age);
        end
        scan_lines(bad);
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL reset_vd: got %0d bad lines want 0", bad);
        end
    endtask

    task automatic test_hit();
        wb_obs_t o;
        logic [63:0] sh;
        sh = (64'd1 << 5) | (64'd1 << 9);
        do_fill(3, 1, 26'h155, 64'h1111_2222_3333_4444, 6'd5, sh);
        do_wb(6'd5, {26'h155, 4'd3}, 64'hDEAD, 0, o);
        void'(model_wb(6'd5, {26'h155, 4'd3}, 64'hDEAD));
        n_checks++;
        if (o.lat !== 3 || o.hit !== 1'b1) begin
            n_fail++;
            $display("FAIL hit_ack: got lat=%0d hit=%b want lat=3 hit=1", o.lat, o.hit);
        end
        n_checks++;
        if (o.typ !== 8'h0D || o.dest !== 6'd5) begin
            n_fail++;
            $display("FAIL hit_hdr: got type=%h dest=%0d want 0d/5", o.typ, o.dest);
        end
        n_checks++;
        if (o.age1 !== 8'd1 || o.age_ack !== 8'd3) begin
            n_fail++;
            $display("FAIL hit_age: got %0d/%0d want 1/3", o.age1, o.age_ack);
        end
        dbg_set = 4'd3; dbg_way = 1'b1;
        #1;
        n_checks++;
        if (dbg_vd !== 2'b11 || dbg_data !== 64'hDEAD || dbg_owner !== 6'd0 ||
            dbg_share !== (64'd1 << 9) || dbg_state !== 2'b00) begin
            n_fail++;
            $display("FAIL hit_line: got vd=%b data=%h own=%0d sh=%h st=%b want 11/dead/0/%h/00",
                     dbg_vd, dbg_data, dbg_owner, dbg_share, dbg_state, 64'd1 << 9);
        end
        n_checks++;
        if (hit_cnt !== 16'd1 || miss_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL hit_cnt: got %0d/%0d want 1/0", hit_cnt, miss_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_miss();
        wb_obs_t o;
        int bad;
        do_wb(6'd7, {26'h2AB, 4'd5}, {$urandom, $urandom}, 0, o);
        void'(model_wb(6'd7, {26'h2AB, 4'd5}, 64'd0));
        n_checks++;
        if (o.lat !== 3 || o.hit !== 1'b0 || o.dest !== 6'd7) begin
            n_fail++;
            $display("FAIL miss_ack: got lat=%0d hit=%b dest=%0d want 3/0/7", o.lat, o.hit, o.dest);
        end
        n_checks++;
        if (miss_cnt !== 16'd1 || hit_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL miss_cnt: got miss=%0d hit=%0d want 1/1", miss_cnt, hit_cnt);
        end
        scan_lines(bad);
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL miss_arrays: got %0d bad lines want 0", bad);
        end
    endtask

    task automatic test_bad_type();
        int bad;
        bad = 0;
        msg3_type = 8'h0A; msg3_source = 6'd3; msg3_addr = {26'h155, 4'd3};
        msg3_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (msg3_ready !== 1'b0 || msg2_valid !== 1'b0 || fill_ready !== 1'b1)
                bad++;
        end
        msg3_valid = 1'b0;
        msg3_type  = 8'h0C;
        #1;
        n_checks++;
        if (bad !== 0 || msg3_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_type: got %0d bad cycles ready_after=%b want 0/1", bad, msg3_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        wb_obs_t o;
        logic exp;
        do_fill(6, 0, 26'h3A5, {$urandom, $urandom}, 6'd2, {$urandom, $urandom});
        do_wb(6'd2, {26'h3A5, 4'd6}, 64'hBEEF, 5, o);
        exp = model_wb(6'd2, {26'h3A5, 4'd6}, 64'hBEEF);
        n_checks++;
        if (o.lat !== 3 || o.hit !== exp) begin
            n_fail++;
            $display("FAIL bp_ack: got lat=%0d hit=%b want 3/%b", o.lat, o.hit, exp);
        end
        n_checks++;
        if (o.unstable !== 0 || o.leaked !== 0) begin
            n_fail++;
            $display("FAIL bp_hold: got unstable=%0d ready_leaks=%0d want 0/0", o.unstable, o.leaked);
        end
        n_checks++;
        if (o.ready_after !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got %b want 1", o.ready_after);
        end
    endtask

    task automatic test_back_to_back();
        wb_obs_t o;
        logic exp;
        for (int i = 0; i < 3; i++) begin
            do_wb(6'(i), {26'h3A5, 4'd6}, 64'(i + 100), 0, o);
            exp = model_wb(6'(i), {26'h3A5, 4'd6}, 64'(i + 100));
            n_checks++;
            if (o.waitc !== 0 || o.ready_after !== 1'b1 || o.lat !== 3 || o.hit !== exp) begin
                n_fail++;
                $display("FAIL b2b_%0d: got wait=%0d rdy=%b lat=%0d hit=%b want 0/1/3/%b",
                         i, o.waitc, o.ready_after, o.lat, o.hit, exp);
            end
        end
    endtask

    task automatic test_same_tag();
        wb_obs_t o;
        int bad;
        do_fill(7, 0, 26'h0AA, 64'hA0, 6'd1, 64'h0);
        do_fill(7, 1, 26'h0AA, 64'hA1, 6'd1, 64'h0);
        do_wb(6'd4, {26'h0AA, 4'd7}, 64'hC0FFEE, 0, o);
        void'(model_wb(6'd4, {26'h0AA, 4'd7}, 64'hC0FFEE));
        dbg_set = 4'd7; dbg_way = 1'b0;
        #1;
        n_checks++;
        if (o.hit !== 1'b1 || dbg_vd !== 2'b11 || dbg_data !== 64'hC0FFEE) begin
            n_fail++;
            $display("FAIL same_tag_way0: got hit=%b vd=%b data=%h want 1/11/c0ffee",
                     o.hit, dbg_vd, dbg_data);
        end
        @(negedge clk);
        scan_lines(bad);
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL same_tag_arrays: got %0d bad lines want 0", bad);
        end
    endtask

    task automatic test_fill_race();
        wb_obs_t o;
        int lat;
        int bad;
        msg3_valid = 1'b1; msg3_type = 8'h0C; msg3_source = 6'd8;
        msg3_addr = {26'h1234, 4'd9}; msg3_data = 64'h5555;
        @(posedge clk);
        @(negedge clk);
        msg3_valid = 1'b0;
        n_checks++;
        if (fill_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL race_fill_ready: got %b want 1", fill_ready);
        end
        fill_set = 4'd9; fill_way = 1'b0; fill_tag = 26'h1234; fill_data = 64'h7777;
        fill_owner = 6'd8; fill_share = 64'hFF; fill_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        fill_valid = 1'b0;
        void'(model_wb(6'd8, {26'h1234, 4'd9}, 64'h5555));
        model_fill(9, 0, 26'h1234, 64'h7777, 6'd8, 64'hFF);
        lat = 2;
        while (msg2_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat !== 3 || msg2_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL race_ack: got lat=%0d hit=%b want 3/0", lat, msg2_hit);
        end
        msg2_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        msg2_ready = 1'b0;
        scan_lines(bad);
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL race_arrays: got %0d bad lines want 0", bad);
        end
        do_wb(6'd8, {26'h1234, 4'd9}, 64'h9999, 0, o);
        void'(model_wb(6'd8, {26'h1234, 4'd9}, 64'h9999));
        n_checks++;
        if (o.hit !== 1'b1) begin
            n_fail++;
            $display("FAIL race_later_hit: got %b want 1", o.hit);
        end
    endtask

    task automatic test_age();
        wb_obs_t o;
        do_wb(6'd1, {26'h3FFFFFF, 4'd15}, 64'd0, 0, o);
        void'(model_wb(6'd1, {26'h3FFFFFF, 4'd15}, 64'd0));
        repeat (300) @(negedge clk);
        n_checks++;
        if (wb_age !== 8'd255) begin
            n_fail++;
            $display("FAIL age_sat: got %0d want 255", wb_age);
        end
        @(negedge clk);
        n_checks++;
        if (wb_age !== 8'd255) begin
            n_fail++;
            $display("FAIL age_hold: got %0d want 255", wb_age);
        end
        do_wb(6'd1, {26'h3FFFFFF, 4'd15}, 64'd0, 0, o);
        void'(model_wb(6'd1, {26'h3FFFFFF, 4'd15}, 64'd0));
        n_checks++;
        if (o.age1 !== 8'd1) begin
            n_fail++;
            $display("FAIL age_restart: got %0d want 1", o.age1);
        end
    endtask

    task automatic test_random();
        wb_obs_t o;
        logic exp;
        logic [25:0] tags [3];
        logic [5:0]  src;
        logic [29:0] addr;
        logic [63:0] d;
        int bad;
        tags[0] = 26'h10; tags[1] = 26'h11; tags[2] = 26'h12;
        for (int i = 0; i < 60; i++) begin
            d = {$urandom, $urandom};
            if ($urandom_range(0, 2) == 0) begin
                do_fill(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                        tags[$urandom_range(0, 2)], d, 6'($urandom_range(0, 7)),
                        {$urandom, $urandom});
            end else begin
                src  = 6'($urandom_range(0, 7));
                addr = {tags[$urandom_range(0, 2)], 4'($urandom_range(0, 3))};
                do_wb(src, addr, d, int'($urandom_range(0, 3)), o);
                exp = model_wb(src, addr, d);
                n_checks++;
                if (o.hit !== exp || o.lat !== 3 || o.dest !== src || o.unstable !== 0) begin
                    n_fail++;
                    $display("FAIL rand_wb_%0d: got hit=%b lat=%0d dest=%0d unst=%0d want %b/3/%0d/0",
                             i, o.hit, o.lat, o.dest, o.unstable, exp, src);
                end
            end
        end
        scan_lines(bad);
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL rand_arrays: got %0d bad lines want 0", bad);
        end
        n_checks++;
        if (hit_cnt !== 16'(m_hits) || miss_cnt !== 16'(m_misses)) begin
            n_fail++;
            $display("FAIL rand_cnt: got %0d/%0d want %0d/%0d", hit_cnt, miss_cnt, m_hits, m_misses);
        end
    endtask

    task automatic test_rst_in_write();
        int bad;
        do_fill(2, 0, 26'h77, 64'h1, 6'd3, 64'h8);
        msg3_valid = 1'b1; msg3_type = 8'h0C; msg3_source = 6'd3;
        msg3_addr = {26'h77, 4'd2}; msg3_data = 64'h2;
        @(posedge clk);
        @(negedge clk);
        msg3_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (fill_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_write_state: got fill_ready=%b want 0", fill_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        bad = 0;
        repeat (6) begin
            if (msg2_valid !== 1'b0)
                bad++;
            @(negedge clk);
        end
        n_checks++;
        if (bad !== 0 || hit_cnt !== 16'd0 || miss_cnt !== 16'd0 || wb_age !== 8'd0) begin
            n_fail++;
            $display("FAIL rst_write_out: got ack_cycles=%0d hit=%0d miss=%0d age=%0d want 0/0/0/0",
                     bad, hit_cnt, miss_cnt, wb_age);
        end
        scan_lines(bad);
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL rst_write_vd: got %0d bad lines want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_miss();
        test_bad_type();
        test_backpressure();
        test_back_to_back();
        test_same_tag();
        test_fill_race();
        test_age();
        test_random();
        test_rst_in_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
